// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types, effect ids and the square-wave step table
// used by the sound-effect player.
package sfx_pkg;

  localparam int MAX_STEPS = 4;

  typedef enum logic [1:0] {
    SFX_POINT = 2'd0,
    SFX_JUMP  = 2'd1,
    SFX_HIT   = 2'd2,
    SFX_STOP  = 2'd3
  } sfx_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  half_period;
    logic [15:0] duration;
  } sfx_step_t;

  // One row per effect id; the STOP row and unused slots are zero, which terminates playback.
  localparam sfx_step_t [0:3][0:MAX_STEPS-1] SFX_TABLE = '{
    '{'{8'd12,  16'd1200}, '{8'd8,   16'd2400}, '{8'd0,   16'd0},    '{8'd0, 16'd0}},
    '{'{8'd24,  16'd2400}, '{8'd16,  16'd2400}, '{8'd0,   16'd0},    '{8'd0, 16'd0}},
    '{'{8'd96,  16'd4800}, '{8'd120, 16'd4800}, '{8'd150, 16'd9600}, '{8'd0, 16'd0}},
    '{'{8'd0,   16'd0},    '{8'd0,   16'd0},    '{8'd0,   16'd0},    '{8'd0, 16'd0}}
  };

  function automatic sfx_step_t sfx_step_lookup(sfx_id_t id, logic [1:0] idx);
    return SFX_TABLE[id][idx];
  endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// sfx_tick_gen: sample-rate divider, one-cycle tick every DIV clocks.
// Counter runs 0..DIV-1; the first tick lands DIV cycles after reset releases.
module sfx_tick_gen #(
  parameter int DIV = 1041
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/sfx_player.sv
// sfx_player: square-wave sound-effect sequencer feeding a PCM sample stream.
// Optional macro SFX_ENVELOPE_EN halves the amplitude on every successive step.
//
// state | meaning
// IDLE  | no effect, ticks emit 0
// LOAD  | one cycle to fetch the current step from the table
// PLAY  | emitting square-wave samples for the current step
module sfx_player
  import sfx_pkg::*;
#(
  parameter int                 CLK_HZ    = 50_000_000,
  parameter int                 SAMPLE_HZ = 48_000,
  parameter logic signed [15:0] AMPLITUDE = 16'sd8000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig_valid,
  input  logic [1:0]         trig_id,
  output logic               trig_ready,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;

  state_t             r_state, w_state_nxt;
  sfx_id_t            r_cur_id;
  logic [1:0]         r_step;
  logic [7:0]         r_half, r_half_cnt;
  logic [15:0]        r_dur;
  logic               r_pol;
  logic               w_tick, w_accept, w_stop, w_start;
  logic               w_step_end, w_last_step;
  sfx_step_t          w_cur_step, w_next_step;
  logic signed [15:0] w_amp, w_sample;

  sfx_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_accept    = trig_valid && trig_ready && !reset;
  assign w_stop      = w_accept && (sfx_id_t'(trig_id) == SFX_STOP);
  assign w_start     = w_accept && (sfx_id_t'(trig_id) != SFX_STOP);
  assign w_cur_step  = sfx_step_lookup(r_cur_id, r_step);
  assign w_next_step = sfx_step_lookup(r_cur_id, r_step + 2'd1);
  assign w_step_end  = (r_dur <= 16'd1);
  assign w_last_step = (r_step == 2'(MAX_STEPS - 1)) || (w_next_step.half_period == 8'd0);

`ifdef SFX_ENVELOPE_EN
  assign w_amp = AMPLITUDE >>> r_step;
`else
  assign w_amp = AMPLITUDE;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = ST_IDLE;
    else if (w_start) w_state_nxt = ST_LOAD;
    else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: w_state_nxt = ST_PLAY;
        ST_PLAY: begin
          if (r_half == 8'd0)              w_state_nxt = ST_IDLE;
          else if (w_tick && w_step_end)   w_state_nxt = w_last_step ? ST_IDLE : ST_LOAD;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != ST_IDLE);
    trig_ready = (r_state == ST_IDLE) || (sfx_id_t'(trig_id) >= r_cur_id);
    w_sample   = '0;
    if (r_state == ST_PLAY) w_sample = r_pol ? w_amp : -w_amp;
  end

  // Step sequencing advances on ticks only; the consumer never stalls it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_id   <= SFX_POINT;
      r_step     <= '0;
      r_half     <= '0;
      r_half_cnt <= '0;
      r_dur      <= '0;
      r_pol      <= 1'b1;
    end else if (w_start) begin
      r_cur_id <= sfx_id_t'(trig_id);
      r_step   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_half     <= w_cur_step.half_period;
          r_half_cnt <= w_cur_step.half_period;
          r_dur      <= w_cur_step.duration;
          r_pol      <= 1'b1;
        end
        ST_PLAY: begin
          if (w_tick) begin
            if (r_half_cnt == 8'd1) begin
              r_pol      <= ~r_pol;
              r_half_cnt <= r_half;
            end else begin
              r_half_cnt <= r_half_cnt - 8'd1;
            end
            r_dur <= r_dur - 16'd1;
            if (w_step_end) r_step <= r_step + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Latest sample wins: a tick overwrites any unconsumed sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (w_tick) begin
      sample_out   <= w_sample;
      sample_valid <= 1'b1;
    end else if (sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: randomized scoreboard bench; the reference model tracks each effect
// as a sample position and derives the waveform from the step table arithmetically.
module tb_sfx_player;

  localparam int CLK_HZ    = 192_000;
  localparam int SAMPLE_HZ = 48_000;
  localparam int DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int AMP       = 8000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               trig_valid = 1'b0;
  logic [1:0]         trig_id = 2'd0;
  logic               sample_ready = 1'b1;
  logic               trig_ready, sample_valid, busy;
  logic signed [15:0] sample_out;

  sfx_player #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ),
    .AMPLITUDE (16'sd8000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trig_valid   (trig_valid),
    .trig_id      (trig_id),
    .trig_ready   (trig_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int HALF [3][4] = '{'{12, 8, 0, 0}, '{24, 16, 0, 0}, '{96, 120, 150, 0}};
  int DUR  [3][4] = '{'{1200, 2400, 0, 0}, '{2400, 2400, 0, 0}, '{4800, 4800, 9600, 0}};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit m_active = 1'b0;
  bit m_loading = 1'b0;
  int m_id = 0;
  int m_pos = 0;
  int m_cnt = 0;
  int exp_q[$];

  function automatic int wave(int id, int pos);
    int start;
    start = 0;
    for (int s = 0; s < 4; s++) begin
      if (HALF[id][s] == 0) break;
      if (pos < start + DUR[id][s]) begin
        int k;
        int amp;
        k = pos - start;
        amp = AMP;
`ifdef SFX_ENVELOPE_EN
        amp = AMP >> s;
`endif
        return (((k / HALF[id][s]) % 2) == 0) ? amp : -amp;
      end
      start += DUR[id][s];
    end
    return 0;
  endfunction

  function automatic int total(int id);
    int t;
    t = 0;
    for (int s = 0; s < 4; s++) begin
      if (HALF[id][s] == 0) break;
      t += DUR[id][s];
    end
    return t;
  endfunction

  function automatic bit model_ready(int id);
    return !m_active || (id >= m_id);
  endfunction

  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on clock edges using only bench-driven inputs.
  always @(posedge clk) begin
    bit tick;
    bit acc;
    int v;
    if (reset) begin
      m_active  = 1'b0;
      m_loading = 1'b0;
      m_id      = 0;
      m_pos     = 0;
      m_cnt     = 0;
      exp_q.delete();
    end else begin
      tick  = (m_cnt == DIV - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      acc   = trig_valid && model_ready(int'(trig_id));
      if (tick) begin
        v = 0;
        if (m_active && !m_loading) begin
          v = wave(m_id, m_pos);
          m_pos++;
          if (m_pos >= total(m_id)) m_active = 1'b0;
        end
        exp_q.delete();
        exp_q.push_back(v);
      end
      m_loading = 1'b0;
      if (acc) begin
        if (trig_id == 2'd3) begin
          m_active = 1'b0;
        end else begin
          m_active  = 1'b1;
          m_loading = 1'b1;
          m_id      = int'(trig_id);
          m_pos     = 0;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("trig_ready", {31'd0, trig_ready}, {31'd0, model_ready(int'(trig_id))});
      chk("sample_valid", {31'd0, sample_valid}, {31'd0, (exp_q.size() != 0)});
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_unexpected: got %0d expected no sample at %0t", sample_out, $time);
        end else begin
          chk("sample_out", sample_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trig(int id);
    trig_valid = 1'b1;
    trig_id    = 2'(id);
    cycles(1);
    trig_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sample_ready = 1'b1;
    cycles(3);
    chk_en = 1'b1;
    reset = 1'b0;

    cycles(10 * DIV);

    trig(1);
    cycles(4820 * DIV);

    trig(2);
    cycles(300 * DIV);
    trig(0);
    cycles(100 * DIV);
    trig(2);
    cycles(500 * DIV);

    trig(1);
    cycles(100 * DIV + 1);
    trig(3);
    cycles(5 * DIV);

    trig(1);
    cycles(50 * DIV);
    sample_ready = 1'b0;
    cycles(3 * DIV);
    sample_ready = 1'b1;
    cycles(60 * DIV);

    trig(2);
    cycles(200 * DIV);
    reset = 1'b1;
    cycles(1);
    chk("reset_sample_out", sample_out, 0);
    chk("reset_sample_valid", {31'd0, sample_valid}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    cycles(20 * DIV);

    for (int i = 0; i < 300; i++) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      cycles($urandom_range(1, 200));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
      end else if ($urandom_range(0, 2) != 0) begin
        trig(int'($urandom_range(0, 3)));
      end
    end
    sample_ready = 1'b1;
    cycles(10 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_player.md
SFX_PLAYER -- requirements
Module: sfx_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter SAMPLE_HZ, default 48_000, output sample rate.
REQ-003 SHALL have parameter AMPLITUDE, default 16'sd8000, square-wave peak magnitude.
REQ-004 SHALL have port clk  input  1  single clock (CLOCK_50 domain), all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port trig_valid  input  1  game logic requests an effect.
REQ-007 SHALL have port trig_id  input  2  0=POINT, 1=JUMP, 2=HIT, 3=STOP.
REQ-008 SHALL have port trig_ready  output  1  trigger accepted when trig_valid && trig_ready at a clock edge.
REQ-009 SHALL have port sample_out  output  16  signed PCM sample to the codec stage.
REQ-010 SHALL have port sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-011 SHALL have port sample_ready  input  1  codec stage consumes the sample on valid && ready.
REQ-012 SHALL have port busy  output  1  high while an effect is playing (not IDLE).

Function
REQ-013 SHALL generate a sample tick with a one-cycle pulse every DIV = CLK_HZ/SAMPLE_HZ cycles (integer division; 1041 at defaults), counter 0..DIV-1.
REQ-014 SHALL implement states IDLE, LOAD, PLAY: IDLE->LOAD on an accepted trigger with id 0-2; LOAD->PLAY after exactly one cycle (step fetch); PLAY->LOAD at end of step; PLAY->IDLE after the final step or a step with half_period==0.
REQ-015 SHALL read each step from a table of {half_period 8 b, duration 16 b}: POINT (12,1200),(8,2400); JUMP (24,2400),(16,2400); HIT (96,4800),(120,4800),(150,9600); at most 4 steps, with half_period==0 terminating.
REQ-016 SHALL in PLAY, on each tick, output +AMPLITUDE or -AMPLITUDE, starting positive at each step, and toggle polarity after every half_period ticks.
REQ-017 SHALL decrement the step duration counter once per tick and end the step when the counter reaches 0 (exactly `duration` samples per step).
REQ-018 SHALL in IDLE and LOAD output sample 0 on each tick, so the stream never stalls.
REQ-019 SHALL load sample_out and set sample_valid on each tick, and clear sample_valid on a handshake without a same-cycle tick.
REQ-020 SHALL on a tick while a sample is pending, overwrite sample_out with the new sample and keep sample_valid high (latest-wins); sequencing SHALL advance on ticks regardless of sample_ready.
REQ-021 SHALL drive trig_ready high in IDLE, and in LOAD/PLAY only when trig_id >= current id (combinational on trig_id).
REQ-022 SHALL on an accepted trigger in LOAD/PLAY with id 0-2, restart at step 0 of the new effect via LOAD.
REQ-023 SHALL on an accepted STOP (id 3), go to IDLE next cycle from any state, so the next tick emits 0; STOP in IDLE SHALL be a no-op.
REQ-024 SHALL drive busy = (state != IDLE).

Reset
REQ-025 SHALL on reset set state IDLE, tick counter 0, sample_out 0, sample_valid 0, busy 0, and current id 0.
REQ-026 SHALL ignore triggers during a reset cycle; reset mid-effect SHALL abort it, and the first post-reset tick occurs DIV cycles after reset deasserts.

Configuration
REQ-027 SHALL, with macro SFX_ENVELOPE_EN defined, set the step amplitude to AMPLITUDE >>> step_index (step 0 full, step 1 half, ...).
REQ-028 SHALL, without SFX_ENVELOPE_EN, use constant AMPLITUDE for all steps, with no envelope logic synthesized.

Structure
REQ-029 SHALL define in package sfx_pkg: sfx_id_t enum, state_t enum, sfx_step_t struct, the step table constant, and MAX_STEPS=4.
REQ-030 SHALL isolate the sample-rate divider in sub-module sfx_tick_gen (clk, reset, tick), parameterised by DIV.

Verification
REQ-031 Reset, idle, sample_ready=1 -> sample_valid pulses every 1041 cycles with sample_out=0 and busy=0.
REQ-032 JUMP trigger -> busy next cycle; first PLAY tick gives +8000 for 24 samples, then -8000 for 24; step 1 starts +8000 after 2400 samples; idle zeros after 4800 samples.
REQ-033 HIT playing, then POINT trigger -> trig_ready=0, effect continues; HIT playing, then HIT trigger -> restart at step 0 (+8000, half_period 96).
REQ-034 JUMP playing, then STOP -> state IDLE next cycle; next tick gives 0; busy=0.
REQ-035 sample_ready=0 for 3 ticks during JUMP -> sample_valid stays 1, sample_out equals the latest tick's value, and the sequence position is unaffected.
REQ-036 With SFX_ENVELOPE_EN, HIT -> step amplitudes 8000, 4000, 2000; reset asserted mid-HIT -> all outputs 0 the next cycle.
